// File: rtl/mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave arbiter in front of the MMU.
// One transaction in flight; satp is sampled while idle and frozen for the transaction.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       csr_satp,
  // IFU read
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic [1:0]        lsu_bresp,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  // MMU side
  output logic [ADDR_W-1:0] s_araddr,
  output logic [2:0]        s_arsize,
  output logic [7:0]        s_arlen,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [31:0]       s_arsatp,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [31:0]       s_awsatp,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);

  typedef enum logic [2:0] {IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_WR, LSU_B} state_t;
  typedef enum logic {M_IFU, M_LSU} mst_t;

  state_t      state, nxt;
  mst_t        rr_last, nxt_rr;
  logic [31:0] satp_q;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs;

  // Payloads pass straight through; only valid/ready are steered by state.
  assign s_arlen   = 8'd0;
  assign s_arburst = 2'b01;
  assign s_arsatp  = satp_q;
  assign s_awsatp  = satp_q;
  assign s_awaddr  = lsu_awaddr;
  assign s_wdata   = lsu_wdata;
  assign s_wstrb   = lsu_wstrb;
  assign ifu_rdata = s_rdata;
  assign ifu_rresp = s_rresp;
  assign lsu_rdata = s_rdata;
  assign lsu_rresp = s_rresp;
  assign lsu_bresp = s_bresp;

  assign aw_hs = (state == LSU_WR) && lsu_awvalid && !aw_done && s_awready;
  assign w_hs  = (state == LSU_WR) && lsu_wvalid && !w_done && s_wready;

  always_comb begin
    nxt         = state;
    nxt_rr      = rr_last;
    s_araddr    = ifu_araddr;
    s_arsize    = 3'b010;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        // Writes first; contended reads go to whoever did not win last time.
        if (lsu_awvalid && lsu_wvalid) begin
          nxt = LSU_WR; nxt_rr = M_LSU;
        end else if (ifu_arvalid && lsu_arvalid) begin
          if (rr_last == M_IFU) begin nxt = LSU_AR; nxt_rr = M_LSU; end
          else                  begin nxt = IFU_AR; nxt_rr = M_IFU; end
        end else if (ifu_arvalid) begin
          nxt = IFU_AR; nxt_rr = M_IFU;
        end else if (lsu_arvalid) begin
          nxt = LSU_AR; nxt_rr = M_LSU;
        end
      end
      IFU_AR: begin
        s_arvalid   = ifu_arvalid;
        ifu_arready = s_arready;
        if (ifu_arvalid && s_arready) nxt = IFU_R;
      end
      IFU_R: begin
        ifu_rvalid = s_rvalid;
        s_rready   = ifu_rready;
        if (s_rvalid && ifu_rready && s_rlast) nxt = IDLE;
      end
      LSU_AR: begin
        s_araddr    = lsu_araddr;
        s_arsize    = lsu_arsize;
        s_arvalid   = lsu_arvalid;
        lsu_arready = s_arready;
        if (lsu_arvalid && s_arready) nxt = LSU_R;
      end
      LSU_R: begin
        lsu_rvalid = s_rvalid;
        s_rready   = lsu_rready;
        if (s_rvalid && lsu_rready && s_rlast) nxt = IDLE;
      end
      LSU_WR: begin
        s_awvalid   = lsu_awvalid && !aw_done;
        s_wvalid    = lsu_wvalid && !w_done;
        lsu_awready = s_awready && !aw_done;
        lsu_wready  = s_wready && !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) nxt = LSU_B;
      end
      LSU_B: begin
        lsu_bvalid = s_bvalid;
        s_bready   = lsu_bready;
        if (s_bvalid && lsu_bready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= M_IFU;
      satp_q  <= 32'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= nxt;
      rr_last <= nxt_rr;
      if (state == IDLE) satp_q <= csr_satp;
      if (state == LSU_WR && nxt != LSU_B) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed master stimulus, behavioural MMU slave,
// negedge monitor popping expected grants/responses.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] csr_satp;
  logic [31:0] ifu_araddr;  logic ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp; logic ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp; logic lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;  logic lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb; logic lsu_wvalid, lsu_wready;
  logic [1:0]  lsu_bresp;   logic lsu_bvalid, lsu_bready;
  logic [31:0] s_araddr;    logic [2:0] s_arsize; logic [7:0] s_arlen; logic [1:0] s_arburst;
  logic        s_arvalid, s_arready; logic [31:0] s_arsatp;
  logic [31:0] s_rdata;     logic [1:0] s_rresp; logic s_rvalid, s_rlast, s_rready;
  logic [31:0] s_awaddr;    logic s_awvalid, s_awready; logic [31:0] s_awsatp;
  logic [31:0] s_wdata;     logic [3:0] s_wstrb; logic s_wvalid, s_wready;
  logic [1:0]  s_bresp;     logic s_bvalid, s_bready;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .csr_satp(csr_satp),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arsatp(s_arsatp),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awsatp(s_awsatp),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int s_aw_cnt = 0, s_w_cnt = 0;
  int rd_delay = 3;
  logic [31:0] exp_satp;
  int          exp_grant_q[$];   // 0 IFU read, 1 LSU read, 2 LSU write
  logic [33:0] exp_ifu_q[$], exp_lsu_q[$];
  logic [1:0]  exp_b_q[$];
  logic [67:0] exp_wr_q[$];

  logic [11:0] hs_vec;
  assign hs_vec = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                   lsu_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++; failures++;
    $display("FAIL %s", nm);
  endtask

  task automatic pop_grant(input int got);
    if (exp_grant_q.size() == 0) fail_msg($sformatf("grant_unexpected got %0d", got));
    else chk("grant_order", 128'(got), 128'(exp_grant_q.pop_front()));
  endtask

  // Behavioural MMU: AR/AW always accepted, read data after rd_delay, W ready one cycle after AW.
  logic        rd_busy;
  int          rd_cnt;
  logic [31:0] rd_addr, wr_addr;
  assign s_arready = 1'b1;
  assign s_awready = 1'b1;
  assign s_rlast   = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      rd_busy <= 1'b0; s_rvalid <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0;
      rd_cnt <= 0; rd_addr <= '0; wr_addr <= '0;
      s_rdata <= '0; s_rresp <= '0; s_bresp <= '0;
    end else begin
      if (s_arvalid && s_arready) begin
        rd_addr <= s_araddr; rd_cnt <= rd_delay; rd_busy <= 1'b1;
      end else if (rd_busy && !s_rvalid) begin
        if (rd_cnt == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= rd_addr ^ 32'h8000_0413;
          s_rresp  <= rd_addr[3:2];
        end else rd_cnt <= rd_cnt - 1;
      end
      if (s_rvalid && s_rready) begin s_rvalid <= 1'b0; rd_busy <= 1'b0; end
      if (s_awvalid && s_awready) begin wr_addr <= s_awaddr; s_wready <= 1'b1; end
      if (s_wvalid && s_wready) begin s_wready <= 1'b0; s_bvalid <= 1'b1; s_bresp <= wr_addr[13:12]; end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ifu_arvalid && ifu_arready) begin
        pop_grant(0);
        chk("ifu_ar_payload", {s_araddr, s_arsize, s_arsatp, s_arlen, s_arburst},
            {ifu_araddr, 3'd2, exp_satp, 8'd0, 2'b01});
      end
      if (lsu_arvalid && lsu_arready) begin
        pop_grant(1);
        chk("lsu_ar_payload", {s_araddr, s_arsize, s_arsatp, s_arlen, s_arburst},
            {lsu_araddr, lsu_arsize, exp_satp, 8'd0, 2'b01});
      end
      if (lsu_awvalid && lsu_awready) begin
        pop_grant(2);
        chk("aw_satp", s_awsatp, exp_satp);
      end
      if (s_awvalid && s_awready) s_aw_cnt++;
      if (s_wvalid && s_wready) begin
        s_w_cnt++;
        if (exp_wr_q.size() == 0) fail_msg("w_unexpected");
        else chk("slave_write", {wr_addr, s_wdata, s_wstrb}, exp_wr_q.pop_front());
      end
      if (ifu_rvalid && ifu_rready) begin
        if (exp_ifu_q.size() == 0) fail_msg("ifu_r_unexpected");
        else chk("ifu_r", {ifu_rresp, ifu_rdata}, exp_ifu_q.pop_front());
      end
      if (lsu_rvalid && lsu_rready) begin
        if (exp_lsu_q.size() == 0) fail_msg("lsu_r_unexpected");
        else chk("lsu_r", {lsu_rresp, lsu_rdata}, exp_lsu_q.pop_front());
      end
      if (lsu_bvalid && lsu_bready) begin
        if (exp_b_q.size() == 0) fail_msg("lsu_b_unexpected");
        else chk("lsu_b", lsu_bresp, exp_b_q.pop_front());
      end
    end
  end

  task automatic do_read(input bit is_lsu, input logic [31:0] a, input logic [2:0] sz,
                         input logic [33:0] er);
    bit ok = 1'b0;
    if (is_lsu) begin
      exp_lsu_q.push_back(er);
      lsu_araddr = a; lsu_arsize = sz; lsu_arvalid = 1'b1;
    end else begin
      exp_ifu_q.push_back(er);
      ifu_araddr = a; ifu_arvalid = 1'b1;
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = is_lsu ? lsu_arready : ifu_arready;
    end
    @(posedge clk) #1;
    if (is_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    if (!ok) fail_msg("ar_timeout");
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] eb);
    bit aw_ok = 1'b0, w_ok = 1'b0, aw_h, w_h;
    exp_b_q.push_back(eb);
    exp_wr_q.push_back({a, d, s});
    lsu_awaddr = a; lsu_awvalid = 1'b1;
    lsu_wdata = d; lsu_wstrb = s; lsu_wvalid = 1'b1;
    for (int i = 0; i < 300 && !(aw_ok && w_ok); i++) begin
      @(negedge clk);
      aw_h = lsu_awvalid && lsu_awready;
      w_h  = lsu_wvalid && lsu_wready;
      @(posedge clk) #1;
      if (aw_h) begin lsu_awvalid = 1'b0; aw_ok = 1'b1; end
      if (w_h)  begin lsu_wvalid  = 1'b0; w_ok  = 1'b1; end
    end
    if (!(aw_ok && w_ok)) fail_msg("write_timeout");
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_grant_q.size() + exp_ifu_q.size() + exp_lsu_q.size() + exp_b_q.size()
            + exp_wr_q.size()) != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    chk(nm, 128'(exp_grant_q.size() + exp_ifu_q.size() + exp_lsu_q.size() + exp_b_q.size()
                 + exp_wr_q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csr_satp = 32'h0000_1234; exp_satp = 32'h0000_1234;
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 1;
    lsu_araddr = '0; lsu_arsize = 3'd2; lsu_arvalid = 0; lsu_rready = 1;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_handshakes", hs_vec, 12'd0);
    chk("reset_satp", s_arsatp, 32'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_satp_load", s_arsatp, 32'h0000_1234);

    // Single IFU fetch
    exp_grant_q.push_back(0);
    @(posedge clk) #1;
    do_read(1'b0, 32'h8000_0000, 3'd2, {2'b00, 32'h0000_0413});
    drain("drain_ifu");

    // Contended reads alternate, LSU first since reset leaves rr_last at IFU
    rd_delay = 1;
    exp_grant_q.push_back(1); exp_grant_q.push_back(0);
    @(posedge clk) #1;
    fork
      do_read(1'b1, 32'h8000_0010, 3'd2, {2'b00, 32'h0000_0403});
      do_read(1'b0, 32'h8000_0004, 3'd2, {2'b01, 32'h0000_0417});
    join
    drain("drain_rr1");
    exp_grant_q.push_back(1); exp_grant_q.push_back(0);
    @(posedge clk) #1;
    fork
      do_read(1'b1, 32'h8000_0020, 3'd1, {2'b00, 32'h0000_0433});
      do_read(1'b0, 32'h8000_0000, 3'd2, {2'b00, 32'h0000_0413});
    join
    drain("drain_rr2");

    // Single write: exactly one AW and one W handshake at the slave
    s_aw_cnt = 0; s_w_cnt = 0;
    exp_grant_q.push_back(2);
    @(posedge clk) #1;
    lsu_write(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 2'b01);
    drain("drain_wr");
    chk("aw_count", 128'(s_aw_cnt), 128'd1);
    chk("w_count", 128'(s_w_cnt), 128'd1);

    // Write beats both reads; then rr_last=LSU hands IFU the next grant
    exp_grant_q.push_back(2); exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    @(posedge clk) #1;
    fork
      lsu_write(32'h8000_2000, 32'h1234_5678, 4'h3, 2'b10);
      do_read(1'b0, 32'h8000_0000, 3'd2, {2'b00, 32'h0000_0413});
      do_read(1'b1, 32'h8000_000C, 3'd0, {2'b11, 32'h0000_041F});
    join
    drain("drain_mix");

    // satp frozen during a transaction, reloaded once idle
    csr_satp = 32'd0; exp_satp = 32'd0;
    repeat (2) @(posedge clk);
    rd_delay = 6;
    exp_grant_q.push_back(0);
    @(posedge clk) #1;
    do_read(1'b0, 32'h8000_0004, 3'd2, {2'b01, 32'h0000_0417});
    csr_satp = 32'h8008_0000;
    @(negedge clk);
    chk("satp_frozen", s_arsatp, 32'd0);
    drain("drain_satp");
    exp_satp = 32'h8008_0000;
    @(posedge clk);
    @(posedge clk) #1;
    chk("satp_reloaded", s_arsatp, 32'h8008_0000);

    // Reset in LSU_R drops the transaction
    rd_delay = 30;
    exp_grant_q.push_back(1);
    @(posedge clk) #1;
    lsu_araddr = 32'h8000_0010; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = lsu_arready; end
      @(posedge clk) #1 lsu_arvalid = 1'b0;
      if (!ok) fail_msg("ar_timeout_rst");
    end
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midtxn_reset_handshakes", hs_vec, 12'd0);
    rst = 1'b0;
    rd_delay = 2;
    chk("grant_q_after_rst", 128'(exp_grant_q.size()), 128'd0);

    // Recovery read after the reset
    exp_grant_q.push_back(0);
    @(posedge clk) #1;
    do_read(1'b0, 32'h8000_0020, 3'd2, {2'b00, 32'h0000_0433});
    drain("drain_recover");
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master to one-slave AXI-lite-style arbiter that sits directly upstream of the MMU. It merges the IFU read port and the LSU read/write port into the single MMU input port. It attaches the current satp CSR value to every request as sideband. Only one transaction is outstanding at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
Grouped lines list related signals; each direction is given per signal.
clk in 1, clock
rst in 1, synchronous active-high reset
csr_satp in 32, live satp CSR value
ifu_araddr in 32 / ifu_arvalid in 1 / ifu_arready out 1, IFU read address (word fetch)
ifu_rdata out 32 / ifu_rresp out 2 / ifu_rvalid out 1 / ifu_rready in 1, IFU read data
lsu_araddr in 32 / lsu_arsize in 3 / lsu_arvalid in 1 / lsu_arready out 1, LSU read address
lsu_rdata out 32 / lsu_rresp out 2 / lsu_rvalid out 1 / lsu_rready in 1, LSU read data
lsu_awaddr in 32 / lsu_awvalid in 1 / lsu_awready out 1, LSU write address
lsu_wdata in 32 / lsu_wstrb in 4 / lsu_wvalid in 1 / lsu_wready out 1, LSU write data
lsu_bresp out 2 / lsu_bvalid out 1 / lsu_bready in 1, LSU write response
s_araddr out 32 / s_arsize out 3 / s_arlen out 8 / s_arburst out 2 / s_arvalid out 1 / s_arready in 1 / s_arsatp out 32, to MMU
s_rdata in 32 / s_rresp in 2 / s_rvalid in 1 / s_rlast in 1 / s_rready out 1, from MMU
s_awaddr out 32 / s_awvalid out 1 / s_awready in 1 / s_awsatp out 32, to MMU
s_wdata out 32 / s_wstrb out 4 / s_wvalid out 1 / s_wready in 1, to MMU
s_bresp in 2 / s_bvalid in 1 / s_bready out 1, from MMU

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_WR, LSU_B. Reset goes to IDLE.
- Reset values:
  - all s_*valid, s_*ready and master ready/valid outputs are 0
  - satp_q = 0
  - aw_done and w_done are 0
  - rr_last = IFU
- Constant slave fields:
  - s_arlen = 0 and s_arburst = 2'b01 always.
  - s_arsize = 3'b010 for IFU; lsu_arsize for LSU.
- IDLE:
  - satp_q <= csr_satp every cycle, so the MMU sees mode changes.
  - Nothing is forwarded; all master readies are 0.
- Arbitration happens in IDLE, one cycle, registered. Priority order:
  1. lsu_awvalid && lsu_wvalid -> LSU_WR.
  2. Both IFU and LSU reads pending -> the one not equal to rr_last wins (round-robin).
  3. Otherwise, the single pending read wins.
  - A lone lsu_awvalid or lsu_wvalid (not both) is not granted.
  - On grant, satp_q freezes and rr_last updates to the winner.
- s_arsatp = s_awsatp = satp_q at all times.
- X_AR states:
  - s_araddr and s_arvalid come from the granted master; that master's arready = s_arready.
  - s_arvalid && s_arready -> X_R.
- X_R states:
  - s_rdata and s_rresp pass to the granted master; its rvalid = s_rvalid; s_rready = its rready.
  - Handshake with s_rlast -> IDLE. Handshake without s_rlast stays (tolerated, not expected).
- LSU_WR:
  - s_awvalid = lsu_awvalid && !aw_done; s_wvalid = lsu_wvalid && !w_done; the master readies mirror these.
  - Set aw_done / w_done on each handshake. When both are done (including the same cycle) -> LSU_B and clear both flags.
- LSU_B:
  - lsu_bvalid = s_bvalid, s_bready = lsu_bready, bresp passes through.
  - Handshake -> IDLE.
- Non-granted master sees ready=0 and valid=0. Masters must hold valid and payload until handshake.
- Minimum latency: request to slave valid is 1 cycle; back-to-back transactions need one IDLE cycle between them.
- A reset mid-transaction returns to IDLE immediately. Outstanding slave transactions are dropped; the slave is reset together with this block.
- rresp and bresp are forwarded unmodified; no error handling here.

Test Plan:
- IFU read 0x8000_0000, slave responds after 3 cycles with rdata 0x00000413, rlast=1 -> ifu_rdata=0x00000413, s_arsize=2, s_arsatp=csr_satp, lsu_rvalid stays 0.
- IFU and LSU reads both asserted in the same cycle, rr_last=IFU -> LSU granted first, IFU next. Repeat and check the grants alternate.
- LSU write awaddr 0x8000_1000, wdata 0xDEADBEEF, wstrb 0xF; slave s_wready one cycle after s_awready -> single s_bvalid to lsu_bvalid, exactly one AW and one W handshake.
- Write and both reads pending together -> write granted first.
- csr_satp changes from 0x0 to 0x80080000 during an IFU read -> s_arsatp stays 0 until IDLE, then updates.
- rst asserted in LSU_R -> next cycle state is IDLE and all valids/readies are 0.
